// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector with overlap/non-overlap matching,
// valid-qualified input bits and a saturating, clearable match counter.
module moore_seq_detector_param #(
  parameter int                 SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = 4'b1011,
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_x,
  input  logic             i_cnt_clr,
  output logic             o_seq_detected,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_count_sat
);

  localparam int SW = $clog2(SEQ_LEN + 1);
  localparam int NS = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t S0       = '0;
  localparam state_t S_DETECT = state_t'(SEQ_LEN);

  // Pattern bit i in arrival order (i = 0 is the first bit received).
  function automatic bit pat_bit(input int i);
    return bit'(SEQ_PATTERN >> (SEQ_LEN - 1 - i));
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, x).
  function automatic int calc_next(input int k, input bit x);
    int best;
    bit ok;
    bit s;
    best = 0;
    for (int j = 1; j <= SEQ_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          s = ((k + 1 - j + t) < k) ? pat_bit(k + 1 - j + t) : x;
          if (s != pat_bit(t)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic int calc_border();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < SEQ_LEN; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        if (pat_bit(SEQ_LEN - j + t) != pat_bit(t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam int DET_START = OVERLAP ? calc_border() : 0;

  state_t w_nxt0 [NS];
  state_t w_nxt1 [NS];

  // Constant next-state table; codes above DETECT are unreachable and fall back to S0.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_tbl
      if (gi < SEQ_LEN) begin : g_match
        assign w_nxt0[gi] = state_t'(calc_next(gi, 1'b0));
        assign w_nxt1[gi] = state_t'(calc_next(gi, 1'b1));
      end else if (gi == SEQ_LEN) begin : g_detect
        assign w_nxt0[gi] = state_t'(calc_next(DET_START, 1'b0));
        assign w_nxt1[gi] = state_t'(calc_next(DET_START, 1'b1));
      end else begin : g_unused
        assign w_nxt0[gi] = S0;
        assign w_nxt1[gi] = S0;
      end
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_sat;
  logic             w_enter_detect;

  always_comb begin
    w_state_next = r_state;
    if (i_valid) begin
      w_state_next = i_x ? w_nxt1[r_state] : w_nxt0[r_state];
    end
  end

  // Gating by i_valid keeps a held DETECT state from counting again.
  assign w_enter_detect = i_valid && (w_state_next == S_DETECT);

  always_comb begin
    w_count_next = r_count;
    if (i_cnt_clr) begin
      w_count_next = w_enter_detect ? CNT_W'(1) : '0;
    end else if (w_enter_detect && (r_count != '1)) begin
      w_count_next = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sat   <= (w_count_next == '1);
    end
  end

  assign o_seq_detected = (r_state == S_DETECT);
  assign o_match_count  = r_count;
  assign o_count_sat    = r_sat;

endmodule
